// File: rtl/squash_input_conditioner.sv
// Conditions the raw active-low button pads for the squash game: synchronise, gate on
// gpio_ready, settle after power-up, then debounce each key and emit press/release pulses.
module squash_input_conditioner #(
    parameter int NUM_KEYS      = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     gpio_ready,
    input  logic [DEBOUNCE_BITS-1:0] debounce_limit,
    input  logic [NUM_KEYS-1:0]      keys_n_in,
    output logic [NUM_KEYS-1:0]      keys_n_out,
    output logic [NUM_KEYS-1:0]      key_press,
    output logic [NUM_KEYS-1:0]      key_release,
    output logic                     inputs_valid
);

    // Settle span is SYNC_STAGES + debounce_limit, so it needs headroom above DEBOUNCE_BITS.
    localparam int SET_W = DEBOUNCE_BITS + 2;

    typedef enum logic [1:0] {
        WAIT_READY,
        SETTLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_cnt_q;
    logic [SET_W-1:0]   settle_target;
    logic               settle_done;
    logic               hold;
    logic               valid_q;

    // While the pads are untrusted everything is parked at its idle value.
    assign hold          = !gpio_ready || (state_q == WAIT_READY);
    assign settle_target = SET_W'(SYNC_STAGES) + SET_W'(debounce_limit);
    assign settle_done   = (state_q == SETTLE) && gpio_ready && (settle_cnt_q >= settle_target);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= WAIT_READY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_READY: if (gpio_ready) state_d = SETTLE;
            SETTLE:     if (settle_done) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = WAIT_READY;
        endcase
        if (!gpio_ready) state_d = WAIT_READY;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || hold || state_q != SETTLE) settle_cnt_q <= '0;
        else                                       settle_cnt_q <= settle_cnt_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || hold)  valid_q <= 1'b0;
        else if (settle_done)  valid_q <= 1'b1;
    end

    assign inputs_valid = valid_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [SYNC_STAGES-1:0]   sync_q;
        logic [DEBOUNCE_BITS-1:0] cnt_q;
        logic                     key_q;
        logic                     press_q;
        logic                     rel_q;
        logic                     synced;

        assign synced = sync_q[SYNC_STAGES-1];

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i || hold) sync_q <= '1;
            else                  sync_q <= {sync_q[SYNC_STAGES-2:0], keys_n_in[i]};
        end

        // The settle commit loads the level silently, so a key held at power-up never pulses.
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i || hold) begin
                cnt_q   <= '0;
                key_q   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (settle_done) begin
                    key_q <= synced;
                    cnt_q <= '0;
                end else if (state_q == RUN) begin
                    if (synced == key_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= debounce_limit) begin
                        key_q   <= synced;
                        cnt_q   <= '0;
                        press_q <= ~synced;
                        rel_q   <= synced;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end

        assign keys_n_out[i]  = key_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
    end

endmodule
